fifo_bank: RTL and testbench

Parametrised bank of NCH independent circular-pointer FIFOs that buffers operand and result streams at the systolic-array edges: one channel per array row/column. Each channel generalises the single-channel edge FIFO:
- configurable word width and any depth, not only powers of two;
- per-channel occupancy, almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- synchronous flush.

Reads are first-word-fall-through.

---
 rtl/fifo_bank_if.sv | 34 +++
 rtl/fifo_bank.sv | 124 ++++++++++++
 tb/tb_fifo_bank.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_bank_if.sv
// Bundles the control, data and status signals of a fifo_bank into one port.
// master drives flush/err_clr/push/pop/dat_in and observes everything else;
// slave (the bank itself) is the mirror image.
interface fifo_bank_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                          flush;
  logic                          err_clr;
  logic [NCH-1:0]                push;
  logic [NCH-1:0]                pop;
  logic [NCH-1:0][WIDTH-1:0]     dat_in;
  logic [NCH-1:0][WIDTH-1:0]     dat_out;
  logic [NCH-1:0][CW-1:0]        ocp;
  logic [NCH-1:0]                is_full;
  logic [NCH-1:0]                is_empty;
  logic [NCH-1:0]                almost_full;
  logic [NCH-1:0]                almost_empty;
  logic [NCH-1:0]                ovf;
  logic [NCH-1:0]                udf;

  modport master (
    output flush, err_clr, push, pop, dat_in,
    input  dat_out, ocp, is_full, is_empty, almost_full, almost_empty, ovf, udf
  );

  modport slave (
    input  flush, err_clr, push, pop, dat_in,
    output dat_out, ocp, is_full, is_empty, almost_full, almost_empty, ovf, udf
  );
endinterface

// File: rtl/fifo_bank.sv
// Bank of NCH independent first-word-fall-through FIFOs, any DEPTH >= 2.
// Latency: a push into an empty channel shows on dat_out the next cycle.
// Backpressure: none; push when full is dropped (ovf), pop when empty is ignored (udf).
//
// Ports: clk, nRST (async active-low); bus (slave) carries flush/err_clr,
// per-channel push/pop/dat_in, and per-channel dat_out, ocp, full/empty,
// almost_full/almost_empty and sticky ovf/udf flags.
module fifo_bank #(
  parameter int NCH    = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         nRST,
  fifo_bank_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0] AF_U = 32'(AF_LVL);
  localparam logic [31:0] AE_U = 32'(AE_LVL);

  // Explicit wrap instead of modulo so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    w_ptr_q, w_ptr_d;
    logic [PW-1:0]    r_ptr_q, r_ptr_d;
    logic [CW-1:0]    ocp_q, ocp_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_en;
    logic             rd_clr;
    logic             empty;
    logic             full;

    assign empty = (ocp_q == '0);
    assign full  = (ocp_q == CW'(DEPTH));

    always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      ocp_d   = ocp_q;
      wr_en   = 1'b0;
      rd_clr  = 1'b0;
      // Clear first so that an error raised in the same cycle survives.
      ovf_d   = bus.err_clr ? 1'b0 : ovf_q;
      udf_d   = bus.err_clr ? 1'b0 : udf_q;

      if (bus.flush) begin
        w_ptr_d = '0;
        r_ptr_d = '0;
        ocp_d   = '0;
      end else if (bus.push[c] && bus.pop[c]) begin
        wr_en   = 1'b1;
        w_ptr_d = ptr_inc(w_ptr_q);
        if (empty) begin
          // Nothing to pop yet; the pop is silently ignored.
          ocp_d = ocp_q + 1'b1;
        end else begin
          // When full, w_ptr == r_ptr: the new word replaces the departing head.
          r_ptr_d = ptr_inc(r_ptr_q);
        end
      end else if (bus.push[c]) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          w_ptr_d = ptr_inc(w_ptr_q);
          ocp_d   = ocp_q + 1'b1;
        end
      end else if (bus.pop[c]) begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          rd_clr  = 1'b1;
          r_ptr_d = ptr_inc(r_ptr_q);
          ocp_d   = ocp_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
        w_ptr_q <= '0;
        r_ptr_q <= '0;
        ocp_q   <= '0;
        ovf_q   <= 1'b0;
        udf_q   <= 1'b0;
      end else begin
        w_ptr_q <= w_ptr_d;
        r_ptr_q <= r_ptr_d;
        ocp_q   <= ocp_d;
        ovf_q   <= ovf_d;
        udf_q   <= udf_d;
      end
    end

    always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (bus.flush) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
        if (rd_clr) mem_q[r_ptr_q] <= '0;
        if (wr_en)  mem_q[w_ptr_q] <= bus.dat_in[c];
      end
    end

    // Head word comes from registered state only.
    assign bus.dat_out[c]      = empty ? '0 : mem_q[r_ptr_q];
    assign bus.ocp[c]          = ocp_q;
    assign bus.is_full[c]      = full;
    assign bus.is_empty[c]     = empty;
    assign bus.almost_full[c]  = (32'(ocp_q) >= AF_U);
    assign bus.almost_empty[c] = (32'(ocp_q) <= AE_U);
    assign bus.ovf[c]          = ovf_q;
    assign bus.udf[c]          = udf_q;
  end
endmodule

// File: tb/tb_fifo_bank.sv
module tb_fifo_bank;
  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  fifo_bank_if #(.NCH(4), .WIDTH(32), .DEPTH(16)) ifa ();
  fifo_bank_if #(.NCH(2), .WIDTH(32), .DEPTH(5))  ifb ();

  fifo_bank #(.NCH(4), .WIDTH(32), .DEPTH(16)) dut_a (.clk(clk), .nRST(nRST), .bus(ifa.slave));
  fifo_bank #(.NCH(2), .WIDTH(32), .DEPTH(5))  dut_b (.clk(clk), .nRST(nRST), .bus(ifb.slave));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: channels 0..3 belong to dut_a (depth 16), 4..5 to dut_b (depth 5).
  logic [31:0] mq [6][$];
  bit          movf [6];
  bit          mudf [6];

  function automatic int dep(input int c);
    return (c < 4) ? 16 : 5;
  endfunction

  bit          m_ps, m_pp, m_fl, m_ec, m_full, m_empty;
  logic [31:0] m_d;

  always @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < 6; c++) begin
        mq[c].delete();
        movf[c] = 1'b0;
        mudf[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 6; c++) begin
        if (c < 4) begin
          m_ps = ifa.push[c]; m_pp = ifa.pop[c]; m_d = ifa.dat_in[c];
          m_fl = ifa.flush;   m_ec = ifa.err_clr;
        end else begin
          m_ps = ifb.push[c-4]; m_pp = ifb.pop[c-4]; m_d = ifb.dat_in[c-4];
          m_fl = ifb.flush;     m_ec = ifb.err_clr;
        end
        m_empty = (mq[c].size() == 0);
        m_full  = (mq[c].size() == dep(c));
        if (m_ec) begin
          movf[c] = 1'b0;
          mudf[c] = 1'b0;
        end
        if (m_fl) begin
          mq[c].delete();
        end else if (m_ps && m_pp) begin
          if (!m_empty) void'(mq[c].pop_front());
          mq[c].push_back(m_d);
        end else if (m_ps) begin
          if (m_full) movf[c] = 1'b1;
          else        mq[c].push_back(m_d);
        end else if (m_pp) begin
          if (m_empty) mudf[c] = 1'b1;
          else         void'(mq[c].pop_front());
        end
      end
    end
  end

  // Every-cycle comparison of all channels against the model.
  logic [31:0] cmp_dat, cmp_edat;
  int          cmp_ocp, cmp_sz, cmp_d;
  logic [5:0]  cmp_fl, cmp_efl;

  always @(negedge clk) begin
    if (nRST && cmp_en) begin
      for (int c = 0; c < 6; c++) begin
        if (c < 4) begin
          cmp_dat = ifa.dat_out[c];
          cmp_ocp = int'(ifa.ocp[c]);
          cmp_fl  = {ifa.is_full[c], ifa.is_empty[c], ifa.almost_full[c],
                     ifa.almost_empty[c], ifa.ovf[c], ifa.udf[c]};
        end else begin
          cmp_dat = ifb.dat_out[c-4];
          cmp_ocp = int'(ifb.ocp[c-4]);
          cmp_fl  = {ifb.is_full[c-4], ifb.is_empty[c-4], ifb.almost_full[c-4],
                     ifb.almost_empty[c-4], ifb.ovf[c-4], ifb.udf[c-4]};
        end
        cmp_sz   = mq[c].size();
        cmp_d    = dep(c);
        cmp_edat = (cmp_sz != 0) ? mq[c][0] : 32'd0;
        cmp_efl  = {cmp_sz == cmp_d, cmp_sz == 0, cmp_sz >= cmp_d - 2, cmp_sz <= 2,
                    movf[c], mudf[c]};
        chk($sformatf("model ch%0d dat_out", c), 64'(cmp_dat), 64'(cmp_edat));
        chk($sformatf("model ch%0d ocp", c), 64'(cmp_ocp), 64'(cmp_sz));
        chk($sformatf("model ch%0d flags", c), 64'(cmp_fl), 64'(cmp_efl));
      end
    end
  end

  task automatic idle_inputs();
    ifa.flush = 1'b0; ifa.err_clr = 1'b0; ifa.push = '0; ifa.pop = '0; ifa.dat_in = '0;
    ifb.flush = 1'b0; ifb.err_clr = 1'b0; ifb.push = '0; ifb.pop = '0; ifb.dat_in = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " a dat_out"},      64'(ifa.dat_out == '0), 64'(1));
    chk({tag, " a ocp"},          64'(ifa.ocp), 64'(0));
    chk({tag, " a is_empty"},     64'(ifa.is_empty), 64'(4'hf));
    chk({tag, " a almost_empty"}, 64'(ifa.almost_empty), 64'(4'hf));
    chk({tag, " a is_full"},      64'(ifa.is_full), 64'(0));
    chk({tag, " a almost_full"},  64'(ifa.almost_full), 64'(0));
    chk({tag, " a ovf/udf"},      64'({ifa.ovf, ifa.udf}), 64'(0));
    chk({tag, " b ocp/flags"},    64'({ifb.ocp, ifb.is_empty, ifb.ovf, ifb.udf}), 64'(12'b000000_11_00_00));
  endtask

  int pp;
  initial begin
    idle_inputs();
    nRST = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    nRST = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Channel 0: fill, overfill, drain in order.
    for (int i = 1; i <= 17; i++) begin
      ifa.push[0] = 1'b1; ifa.dat_in[0] = i;
      tick();
    end
    ifa.push[0] = 1'b0;
    chk("ch0 full ocp", 64'(ifa.ocp[0]), 64'(16));
    chk("ch0 is_full", 64'(ifa.is_full[0]), 64'(1));
    chk("ch0 ovf", 64'(ifa.ovf[0]), 64'(1));
    for (int i = 1; i <= 16; i++) begin
      chk("ch0 pop order", 64'(ifa.dat_out[0]), 64'(i));
      ifa.pop[0] = 1'b1;
      tick();
    end
    ifa.pop[0] = 1'b0;
    chk("ch0 drained empty", 64'(ifa.is_empty[0]), 64'(1));
    chk("ch0 drained dat_out", 64'(ifa.dat_out[0]), 64'(0));
    chk("ch1..3 untouched ocp", 64'({ifa.ocp[3], ifa.ocp[2], ifa.ocp[1]}), 64'(0));
    ifa.err_clr = 1'b1; tick(); ifa.err_clr = 1'b0;
    chk("ch0 ovf cleared", 64'(ifa.ovf[0]), 64'(0));

    // Channel 1: push+pop while full.
    for (int i = 1; i <= 16; i++) begin
      ifa.push[1] = 1'b1; ifa.dat_in[1] = i;
      tick();
    end
    chk("ch1 head before", 64'(ifa.dat_out[1]), 64'(1));
    ifa.pop[1] = 1'b1; ifa.dat_in[1] = 99;
    tick();
    ifa.push[1] = 1'b0; ifa.pop[1] = 1'b0;
    chk("ch1 full pushpop ocp", 64'(ifa.ocp[1]), 64'(16));
    chk("ch1 full pushpop ovf", 64'(ifa.ovf[1]), 64'(0));
    for (int k = 0; k < 16; k++) begin
      chk("ch1 order after pushpop", 64'(ifa.dat_out[1]), 64'((k < 15) ? k + 2 : 99));
      ifa.pop[1] = 1'b1;
      tick();
    end
    ifa.pop[1] = 1'b0;

    // Channel 2: push+pop on empty, then underflow stickiness.
    ifa.push[2] = 1'b1; ifa.pop[2] = 1'b1; ifa.dat_in[2] = 7;
    tick();
    ifa.push[2] = 1'b0; ifa.pop[2] = 1'b0;
    chk("ch2 empty pushpop ocp", 64'(ifa.ocp[2]), 64'(1));
    chk("ch2 empty pushpop dat", 64'(ifa.dat_out[2]), 64'(7));
    chk("ch2 empty pushpop udf", 64'(ifa.udf[2]), 64'(0));
    ifa.pop[2] = 1'b1; tick();
    tick();
    ifa.pop[2] = 1'b0;
    chk("ch2 udf set", 64'(ifa.udf[2]), 64'(1));
    tick();
    chk("ch2 udf sticky", 64'(ifa.udf[2]), 64'(1));
    ifa.err_clr = 1'b1; ifa.pop[2] = 1'b1; tick();
    ifa.pop[2] = 1'b0;
    chk("ch2 new error beats clr", 64'(ifa.udf[2]), 64'(1));
    tick();
    ifa.err_clr = 1'b0;
    chk("ch2 udf cleared", 64'(ifa.udf[2]), 64'(0));

    // Channel 3: flush with a concurrent push; flags survive flush.
    ifa.pop[2] = 1'b1; tick(); ifa.pop[2] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ifa.push[3] = 1'b1; ifa.dat_in[3] = 100 + i;
      tick();
    end
    chk("ch3 ocp 9", 64'(ifa.ocp[3]), 64'(9));
    chk("ch3 almost flags", 64'({ifa.almost_full[3], ifa.almost_empty[3]}), 64'(0));
    ifa.flush = 1'b1; ifa.dat_in[3] = 555;
    tick();
    ifa.flush = 1'b0; ifa.push[3] = 1'b0;
    chk("ch3 flush ocp", 64'(ifa.ocp[3]), 64'(0));
    chk("ch3 flush dat_out", 64'(ifa.dat_out[3]), 64'(0));
    chk("flush keeps udf", 64'(ifa.udf[2]), 64'(1));
    ifa.err_clr = 1'b1; tick(); ifa.err_clr = 1'b0;

    // Depth-5 bank: pointer wrap.
    for (int i = 1; i <= 4; i++) begin
      ifb.push[0] = 1'b1; ifb.dat_in[0] = i; tick();
    end
    ifb.push[0] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("d5 first pops", 64'(ifb.dat_out[0]), 64'(i));
      ifb.pop[0] = 1'b1; tick();
    end
    ifb.pop[0] = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      ifb.push[0] = 1'b1; ifb.dat_in[0] = i; tick();
    end
    ifb.push[0] = 1'b0;
    chk("d5 full ocp", 64'(ifb.ocp[0]), 64'(5));
    chk("d5 is_full", 64'(ifb.is_full[0]), 64'(1));
    for (int i = 4; i <= 8; i++) begin
      chk("d5 wrapped pops", 64'(ifb.dat_out[0]), 64'(i));
      ifb.pop[0] = 1'b1; tick();
    end
    ifb.pop[0] = 1'b0;
    chk("d5 drained dat_out", 64'(ifb.dat_out[0]), 64'(0));

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      ifa.push[0] = 1'b1; ifa.dat_in[0] = 32'hA0 + i; ifb.push[1] = 1'b1; ifb.dat_in[1] = i;
      ifa.pop[2] = 1'b1;
      tick();
    end
    idle_inputs();
    @(posedge clk);
    #2 nRST = 1'b0;
    #1 chk_reset_outputs("midstream reset");
    tick();
    nRST = 1'b1;
    ifa.push[0] = 1'b1; ifa.dat_in[0] = 32'h55;
    tick();
    ifa.push[0] = 1'b0;
    chk("post reset push dat", 64'(ifa.dat_out[0]), 64'(32'h55));
    chk("post reset push ocp", 64'(ifa.ocp[0]), 64'(1));

    // Randomized traffic with phases biased toward full, empty and balanced.
    for (int n = 0; n < 3000; n++) begin
      case ((n / 250) % 3)
        0: pp = 80;
        1: pp = 20;
        default: pp = 50;
      endcase
      for (int c = 0; c < 4; c++) begin
        ifa.push[c]   = ($urandom_range(0, 99) < pp);
        ifa.pop[c]    = ($urandom_range(0, 99) < 100 - pp);
        ifa.dat_in[c] = $urandom;
      end
      for (int c = 0; c < 2; c++) begin
        ifb.push[c]   = ($urandom_range(0, 99) < pp);
        ifb.pop[c]    = ($urandom_range(0, 99) < 100 - pp);
        ifb.dat_in[c] = $urandom;
      end
      ifa.flush   = ($urandom_range(0, 127) == 0);
      ifb.flush   = ($urandom_range(0, 127) == 0);
      ifa.err_clr = ($urandom_range(0, 31) == 0);
      ifb.err_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle_inputs();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
